// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } state_t;

   // Grant ids stored in last_grant
   localparam logic GRANT_I = 1'b0;
   localparam logic GRANT_D = 1'b1;

   // Bit positions in the one-hot winner vector
   localparam int unsigned WIN_I = 0;
   localparam int unsigned WIN_D = 1;

   localparam int unsigned WAIT_W = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and shared-memory signal bundle for mem_arbiter.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) ();
   localparam int unsigned STRB_W = DATA_W / 8;

   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              i_ack;
   logic              i_err;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [STRB_W-1:0] d_wstrb;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ack;
   logic              d_err;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [STRB_W-1:0] mem_wstrb;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
      output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
      input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin winner select: on a tie the requester not granted last wins.
module arb_rr2
   import mem_arbiter_pkg::*;
(
   input  logic       i_req_i,
   input  logic       i_req_d,
   input  logic       i_last_grant,
   output logic [1:0] o_win_c
);

   always_comb begin
      o_win_c = 2'b00;
      if (i_req_i && i_req_d) begin
         if (i_last_grant == GRANT_I) o_win_c[WIN_D] = 1'b1;
         else                         o_win_c[WIN_I] = 1'b1;
      end else if (i_req_i) begin
         o_win_c[WIN_I] = 1'b1;
      end else if (i_req_d) begin
         o_win_c[WIN_D] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requests onto one single-port memory,
// with round-robin ties, payload latching at grant and a bounded wait.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);
   localparam int unsigned STRB_W = DATA_W / 8;

   state_t            r_state,  w_state_nxt;
   logic              r_last,   w_last_nxt;
   logic [WAIT_W-1:0] r_wait,   w_wait_nxt;
   logic              r_we,     w_we_nxt;
   logic [ADDR_W-1:0] r_addr,   w_addr_nxt;
   logic [DATA_W-1:0] r_wdata,  w_wdata_nxt;
   logic [STRB_W-1:0] r_wstrb,  w_wstrb_nxt;

   logic [1:0] w_win;
   logic       w_timeout;
   logic       w_done;
   logic       w_grant_i;
   logic       w_grant_d;

   arb_rr2 u_arb (
      .i_req_i      (bus.i_req),
      .i_req_d      (bus.d_req),
      .i_last_grant (r_last),
      .o_win_c      (w_win)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_last  <= GRANT_I;
         r_wait  <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
         r_wait  <= w_wait_nxt;
         r_we    <= w_we_nxt;
         r_addr  <= w_addr_nxt;
         r_wdata <= w_wdata_nxt;
         r_wstrb <= w_wstrb_nxt;
      end
   end

   // Next state; a completing grant hands over directly to a waiting other side
   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      w_wait_nxt  = r_wait;
      w_we_nxt    = r_we;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      w_wstrb_nxt = r_wstrb;
      w_done      = 1'b0;
      w_grant_i   = 1'b0;
      w_grant_d   = 1'b0;
      w_timeout   = (r_wait == WAIT_W'(TIMEOUT - 1)) && !bus.mem_ready;

      case (r_state)
         IDLE: begin
            w_grant_i = w_win[WIN_I];
            w_grant_d = w_win[WIN_D];
         end
         GNT_I: begin
            w_done = bus.mem_ready || w_timeout;
            if (w_done) begin
               if (bus.d_req) w_grant_d   = 1'b1;
               else           w_state_nxt = IDLE;
            end else begin
               w_wait_nxt = r_wait + WAIT_W'(1);
            end
         end
         GNT_D: begin
            w_done = bus.mem_ready || w_timeout;
            if (w_done) begin
               if (bus.i_req) w_grant_i   = 1'b1;
               else           w_state_nxt = IDLE;
            end else begin
               w_wait_nxt = r_wait + WAIT_W'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      if (w_grant_i) begin
         w_state_nxt = GNT_I;
         w_last_nxt  = GRANT_I;
         w_wait_nxt  = '0;
         w_we_nxt    = 1'b0;
         w_addr_nxt  = bus.i_addr;
         w_wdata_nxt = '0;
         w_wstrb_nxt = '0;
      end
      if (w_grant_d) begin
         w_state_nxt = GNT_D;
         w_last_nxt  = GRANT_D;
         w_wait_nxt  = '0;
         w_we_nxt    = bus.d_we;
         w_addr_nxt  = bus.d_addr;
         w_wdata_nxt = bus.d_wdata;
         w_wstrb_nxt = bus.d_wstrb;
      end
   end

   assign bus.mem_req   = (r_state == GNT_I) || (r_state == GNT_D);
   assign bus.mem_we    = r_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.mem_wstrb = r_wstrb;

   assign bus.i_ack   = (r_state == GNT_I) && w_done;
   assign bus.i_err   = (r_state == GNT_I) && w_timeout;
   assign bus.d_ack   = (r_state == GNT_D) && w_done;
   assign bus.d_err   = (r_state == GNT_D) && w_timeout;
   assign bus.i_rdata = bus.mem_rdata;
   assign bus.d_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_mem_arbiter;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int          TO = 4;

   logic clk;
   logic rst;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      bus.i_req = 0; bus.i_addr = '0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
      bus.mem_ready = 0; bus.mem_rdata = '0;
   endtask

   // Leaves the bench at posedge+1 with rst just released
   task automatic do_reset();
      rst = 1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        i_req, d_req, rdy;
      logic        mreq, iack, dack, ierr, derr;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  strb;
   } vec_t;

   vec_t vt [18];

   function automatic int pick(input bit ir, input bit dr, input int last);
      if (ir && dr) return (last == 1) ? 2 : 1;
      if (ir) return 1;
      if (dr) return 2;
      return 0;
   endfunction

   int m_owner, m_wait, m_last, other, p, n_acks, n_iack, n_dack;
   bit i_on, d_on, i_ackd, d_ackd, exp_done, exp_err;
   int ack_seq [10];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1;
      idle_inputs();

      // ---- reset state ----
      repeat (2) @(posedge clk);
      #1;
      bus.mem_ready = 1;
      bus.i_req = 1; bus.d_req = 1;
      @(negedge clk);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_mem_wstrb", bus.mem_wstrb, 0);
      chk("rst_acks", {bus.i_ack, bus.d_ack, bus.i_err, bus.d_err}, 0);

      // ---- directed vector table ----
      vt[0]  = '{0,0,0, 0,0,0,0,0, 32'h0,    0, 4'h0};
      vt[1]  = '{1,1,0, 0,0,0,0,0, 32'h0,    0, 4'h0};
      vt[2]  = '{1,1,1, 1,0,1,0,0, 32'h2000, 1, 4'hF};
      vt[3]  = '{1,0,1, 1,1,0,0,0, 32'h100,  0, 4'h0};
      vt[4]  = '{0,0,1, 0,0,0,0,0, 32'h0,    0, 4'h0};
      vt[5]  = '{1,0,0, 0,0,0,0,0, 32'h0,    0, 4'h0};
      vt[6]  = '{1,0,0, 1,0,0,0,0, 32'h100,  0, 4'h0};
      vt[7]  = '{1,0,1, 1,1,0,0,0, 32'h100,  0, 4'h0};
      vt[8]  = '{0,1,0, 0,0,0,0,0, 32'h0,    0, 4'h0};
      vt[9]  = '{0,1,0, 1,0,0,0,0, 32'h2000, 1, 4'hF};
      vt[10] = '{0,1,0, 1,0,0,0,0, 32'h2000, 1, 4'hF};
      vt[11] = '{0,1,0, 1,0,0,0,0, 32'h2000, 1, 4'hF};
      vt[12] = '{0,1,0, 1,0,1,0,1, 32'h2000, 1, 4'hF};
      vt[13] = '{0,0,0, 0,0,0,0,0, 32'h0,    0, 4'h0};
      vt[14] = '{0,1,0, 0,0,0,0,0, 32'h0,    0, 4'h0};
      vt[15] = '{1,1,0, 1,0,0,0,0, 32'h2000, 1, 4'hF};
      vt[16] = '{0,1,1, 1,0,1,0,0, 32'h2000, 1, 4'hF};
      vt[17] = '{0,0,0, 0,0,0,0,0, 32'h0,    0, 4'h0};

      do_reset();
      bus.i_addr = 32'h100;
      bus.d_addr = 32'h2000; bus.d_we = 1; bus.d_wstrb = 4'hF; bus.d_wdata = 32'hCAFE_0001;
      bus.mem_rdata = 32'h1234_5678;
      for (int r = 0; r < 18; r++) begin
         bus.i_req = vt[r].i_req;
         bus.d_req = vt[r].d_req;
         bus.mem_ready = vt[r].rdy;
         @(negedge clk);
         chk($sformatf("vec%0d_mem_req", r), bus.mem_req, vt[r].mreq);
         chk($sformatf("vec%0d_i_ack", r), bus.i_ack, vt[r].iack);
         chk($sformatf("vec%0d_d_ack", r), bus.d_ack, vt[r].dack);
         chk($sformatf("vec%0d_i_err", r), bus.i_err, vt[r].ierr);
         chk($sformatf("vec%0d_d_err", r), bus.d_err, vt[r].derr);
         if (vt[r].mreq) begin
            chk($sformatf("vec%0d_mem_addr", r), bus.mem_addr, vt[r].addr);
            chk($sformatf("vec%0d_mem_we", r), bus.mem_we, vt[r].we);
            chk($sformatf("vec%0d_mem_wstrb", r), bus.mem_wstrb, vt[r].strb);
         end
         if (vt[r].iack) chk($sformatf("vec%0d_i_rdata", r), bus.i_rdata, 32'h1234_5678);
         if (vt[r].dack) chk($sformatf("vec%0d_d_rdata", r), bus.d_rdata, 32'h1234_5678);
         step();
      end

      // ---- reset mid-transaction ----
      do_reset();
      bus.i_req = 1; bus.i_addr = 32'h200;
      step();
      @(negedge clk);
      chk("rmid_gnt_mem_req", bus.mem_req, 1);
      chk("rmid_gnt_addr", bus.mem_addr, 32'h200);
      #2;
      bus.mem_ready = 1;
      rst = 1;
      #1;
      chk("rmid_mem_req_now", bus.mem_req, 0);
      chk("rmid_no_ack", bus.i_ack, 0);
      chk("rmid_addr_clr", bus.mem_addr, 0);
      step();
      chk("rmid_held_mem_req", bus.mem_req, 0);
      bus.i_addr = 32'h300;
      rst = 0;
      @(negedge clk);
      chk("rmid_no_early_grant", bus.mem_req, 0);
      step();
      @(negedge clk);
      chk("rmid_regrant_req", bus.mem_req, 1);
      chk("rmid_regrant_addr", bus.mem_addr, 32'h300);
      chk("rmid_regrant_ack", bus.i_ack, 1);
      step();

      // ---- payload stability during grant ----
      bus.i_req = 0; bus.mem_ready = 0;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40;
      @(negedge clk);
      chk("stab_idle", bus.mem_req, 0);
      step();
      bus.d_addr = 32'h80;
      @(negedge clk);
      chk("stab_addr_w", bus.mem_addr, 32'h40);
      chk("stab_no_ack", bus.d_ack, 0);
      step();
      bus.mem_ready = 1;
      @(negedge clk);
      chk("stab_addr_ack", bus.mem_addr, 32'h40);
      chk("stab_ack", bus.d_ack, 1);
      step();
      bus.d_req = 0; bus.mem_ready = 0;

      // ---- sustained contention ----
      do_reset();
      bus.i_req = 1; bus.d_req = 1; bus.mem_ready = 1;
      n_acks = 0;
      for (int c = 0; c < 40 && n_acks < 10; c++) begin
         @(negedge clk);
         if (bus.i_ack && n_acks < 10) begin ack_seq[n_acks] = 1; n_acks++; end
         if (bus.d_ack && n_acks < 10) begin ack_seq[n_acks] = 2; n_acks++; end
         step();
      end
      chk("cont_ack_count", 64'(n_acks), 10);
      for (int k = 0; k < n_acks; k++)
         chk($sformatf("cont_order%0d", k), 64'(ack_seq[k]), (k % 2 == 0) ? 2 : 1);

      // ---- randomized run against a transaction-level model ----
      do_reset();
      m_owner = 0; m_wait = 0; m_last = 1;
      i_on = 0; d_on = 0; i_ackd = 0; d_ackd = 0;
      n_iack = 0; n_dack = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         // requesters hold until ack, then drop or renew with a new payload
         if (i_ackd) begin
            i_on = ($urandom_range(0, 1) == 1);
            if (i_on) bus.i_addr = $urandom;
         end else if (!i_on && $urandom_range(0, 2) == 0) begin
            i_on = 1; bus.i_addr = $urandom;
         end
         if (d_ackd) begin
            d_on = ($urandom_range(0, 1) == 1);
         end else if (!d_on && $urandom_range(0, 2) == 0) begin
            d_on = 1;
            d_ackd = 1;
         end
         if (d_on && d_ackd) begin
            bus.d_we = 1'($urandom_range(0, 1));
            bus.d_addr = $urandom; bus.d_wdata = $urandom; bus.d_wstrb = 4'($urandom);
         end
         bus.i_req = i_on;
         bus.d_req = d_on;
         bus.mem_ready = ($urandom_range(0, 99) < 55);
         bus.mem_rdata = $urandom;
         @(negedge clk);

         exp_done = 0; exp_err = 0;
         if (m_owner != 0) begin
            exp_done = bus.mem_ready || (m_wait == TO - 1);
            exp_err  = exp_done && !bus.mem_ready;
         end
         chk("rnd_mem_req", bus.mem_req, m_owner != 0);
         chk("rnd_i_ack", bus.i_ack, m_owner == 1 && exp_done);
         chk("rnd_d_ack", bus.d_ack, m_owner == 2 && exp_done);
         chk("rnd_i_err", bus.i_err, m_owner == 1 && exp_err);
         chk("rnd_d_err", bus.d_err, m_owner == 2 && exp_err);
         if (m_owner == 1) begin
            chk("rnd_i_addr", bus.mem_addr, bus.i_addr);
            chk("rnd_i_we", bus.mem_we, 0);
            chk("rnd_i_strb", bus.mem_wstrb, 0);
            if (exp_done) chk("rnd_i_rdata", bus.i_rdata, bus.mem_rdata);
         end
         if (m_owner == 2) begin
            chk("rnd_d_addr", bus.mem_addr, bus.d_addr);
            chk("rnd_d_we", bus.mem_we, bus.d_we);
            chk("rnd_d_wdata", bus.mem_wdata, bus.d_wdata);
            chk("rnd_d_strb", bus.mem_wstrb, bus.d_wstrb);
            if (exp_done) chk("rnd_d_rdata", bus.d_rdata, bus.mem_rdata);
         end

         i_ackd = (m_owner == 1) && exp_done;
         d_ackd = (m_owner == 2) && exp_done;
         if (i_ackd) n_iack++;
         if (d_ackd) n_dack++;

         // who owns the memory next cycle
         if (m_owner == 0) begin
            p = pick(i_on, d_on, m_last);
            if (p != 0) begin m_owner = p; m_wait = 0; m_last = p; end
         end else if (exp_done) begin
            other = 3 - m_owner;
            if ((other == 1 && i_on) || (other == 2 && d_on)) begin
               m_owner = other; m_wait = 0; m_last = other;
            end else begin
               m_owner = 0;
            end
         end else begin
            m_wait++;
         end
         step();
      end
      chk("rnd_i_served", n_iack > 0, 1);
      chk("rnd_d_served", n_dack > 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the address width.
REQ-002 SHALL have parameter DATA_W, default 32, the data width; strobe width is DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT, default 255, the maximum number of grant cycles waiting on mem_ready (range 2..255).
REQ-004 SHALL have port clk  in  1  the single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports i_req in 1 (fetch request) and i_addr in ADDR_W (fetch address).
REQ-007 SHALL have ports i_rdata out DATA_W (fetch data), i_ack out 1 (fetch done pulse) and i_err out 1 (fetch timeout pulse).
REQ-008 SHALL have ports d_req in 1, d_we in 1, d_addr in ADDR_W, d_wdata in DATA_W and d_wstrb in DATA_W/8, the load/store request from the MEM stage.
REQ-009 SHALL have ports d_rdata out DATA_W, d_ack out 1 and d_err out 1.
REQ-010 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W and mem_wstrb out DATA_W/8, the shared single-port memory request.
REQ-011 SHALL have ports mem_ready in 1 (memory completes the current access this cycle) and mem_rdata in DATA_W (read data valid with mem_ready).

Function
REQ-012 SHALL implement FSM states IDLE, GNT_I and GNT_D.
REQ-013 In IDLE with exactly one of i_req or d_req high, SHALL go to that requester's GNT state on the next edge.
REQ-014 In IDLE with both requests high, SHALL grant the requester not recorded in last_grant (round-robin).
REQ-015 On every grant, SHALL latch the winner's address, we, wdata and wstrb; mem_* outputs SHALL be driven only from these latched registers.
REQ-016 Fetch grants SHALL latch mem_we=0 and mem_wstrb=0.
REQ-017 mem_req SHALL be 1 exactly while the state is GNT_I or GNT_D.
REQ-018 In GNT_x with mem_ready=1, SHALL assert x_ack combinationally in the same cycle.
REQ-019 x_rdata SHALL be mem_rdata passed through; it is valid only while x_ack=1, and data is don't-care for writes.
REQ-020 On completion from GNT_x, SHALL go to the other GNT state if the other requester's req is high, else to IDLE; it SHALL never go directly to the same GNT state.
REQ-021 last_grant SHALL update to x on each grant of x.
REQ-022 A wait counter SHALL clear on grant and increment each GNT cycle without mem_ready.
REQ-023 If the wait counter reaches TIMEOUT-1 with mem_ready=0, SHALL assert x_ack=1 and x_err=1 in that cycle and leave GNT as in REQ-020.
REQ-024 x_err SHALL be 1 only together with x_ack.
REQ-025 Minimum latency SHALL be 2 cycles (req seen in IDLE -> mem_req next cycle -> ack in that cycle if mem_ready=1).
REQ-026 Requesters hold req and payload stable until ack and drop or renew req in the cycle after ack; payload changes while req=1 before ack SHALL be ignored.
REQ-027 A req dropped before grant SHALL simply not be granted; no ack SHALL be produced for it.
REQ-028 mem_ready outside a GNT state SHALL be ignored.
REQ-029 At most one of i_ack and d_ack SHALL be 1 in any cycle.

Reset
REQ-030 rst=1 SHALL force immediately, regardless of clk: state=IDLE, last_grant=I (so data wins the first tie), wait counter=0 and latched payload=0.
REQ-031 rst=1 SHALL force immediately: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, i_ack=0, d_ack=0, i_err=0 and d_err=0.
REQ-032 Assertion of rst mid-transaction SHALL abandon the access with no ack.
REQ-033 The first grant SHALL occur no earlier than the first rising edge after rst deasserts.

Structure
REQ-034 FSM state encodings (IDLE=2'd0, GNT_I=2'd1, GNT_D=2'd2) and the grant-id constants SHALL live in the shared core package/header.
REQ-035 The two-input round-robin winner selection SHALL be one sub-module, arb_rr2 (inputs: two requests and last_grant; outputs: one-hot winner).

Verification
REQ-036 Single fetch: i_req=1, i_addr=0x100, mem_ready=1 on first GNT cycle -> mem_req cycle 1 with mem_addr=0x100 and mem_we=0; i_ack cycle 1 with i_rdata=mem_rdata.
REQ-037 Tie after reset: i_req=d_req=1 (d_addr=0x2000, d_we=1, d_wstrb=4'hF) -> D granted first and d_ack; then GNT_I directly with no IDLE cycle; then IDLE.
REQ-038 Sustained contention: both req held continuously for 10 transactions -> grants alternate D,I,D,I,...; neither requester is starved.
REQ-039 Timeout: d_req=1, mem_ready=0 forever, TIMEOUT=4 -> d_ack=d_err=1 on the 4th GNT_D cycle; mem_req=0 next cycle.
REQ-040 Reset mid-op: rst=1 asserted between edges during GNT_I -> mem_req=0 immediately; no i_ack; after release with i_req=1, a fresh grant with latched i_addr.
REQ-041 Payload stability: change d_addr 0x40->0x80 during GNT_D -> mem_addr stays 0x40 until d_ack.
